// File: rtl/mii_phy_rx_stream_gen.sv
// PHY-side MII receive stream generator: preamble, SFD, payload nibbles,
// optional CRC-32 FCS and inter-frame gap, driven from a byte handshake.
module mii_phy_rx_stream_gen #(
  parameter int PREAMBLE_BYTES = 7,
  parameter bit APPEND_FCS     = 1'b1,
  parameter int IFG_NIBBLES    = 24
) (
  input  logic       i_mrx_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_data_last,
  input  logic       i_err_inject,
  output logic       o_data_ready,
  output logic [3:0] o_mrxd,
  output logic       o_mrxdv,
  output logic       o_mrxerr,
  output logic       o_busy,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DLO,
    S_DHI, S_FCS, S_ABORT, S_IFG
  } state_e;

  localparam logic [15:0] PRE_LAST =
    16'(2 * PREAMBLE_BYTES - 1);
  localparam logic [15:0] IFG_LAST =
    16'(IFG_NIBBLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] crc_q, crc_d;
  logic        ready_q, ready_d;
  logic        take;
  logic [31:0] fcs;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge i_mrx_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      crc_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      err_q   <= err_d;
      crc_q   <= crc_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    take    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ready_q && i_data_valid) begin
          take    = 1'b1;
          crc_d   = crc_step('1, i_data);
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SFD: begin
        if (cnt_q[0]) begin
          state_d = S_DLO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DLO: state_d = S_DHI;
      S_DHI: begin
        cnt_d = '0;
        if (last_q) begin
          state_d = APPEND_FCS ? S_FCS : S_IFG;
        end else if (ready_q && i_data_valid) begin
          take    = 1'b1;
          crc_d   = crc_step(crc_q, i_data);
          state_d = S_DLO;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_FCS: begin
        if (cnt_q[2:0] == 3'd7) begin
          state_d = S_IFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ABORT: begin
        state_d = S_IFG;
        cnt_d   = '0;
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    byte_d = take ? i_data       : byte_q;
    last_d = take ? i_data_last  : last_q;
    err_d  = take ? i_err_inject : err_q;
    // Ready drops for the first IDLE cycle so a held byte waits one clock
    ready_d = (state_q == S_IDLE && state_d == S_IDLE) ||
              (state_d == S_DHI && !last_d);
  end

  assign fcs = ~crc_q;

  always_comb begin
    o_mrxd     = 4'h0;
    o_mrxdv    = 1'b0;
    o_mrxerr   = 1'b0;
    o_underrun = 1'b0;
    unique case (state_q)
      S_PRE: begin
        o_mrxdv = 1'b1;
        o_mrxd  = 4'h5;
      end
      S_SFD: begin
        o_mrxdv = 1'b1;
        o_mrxd  = cnt_q[0] ? 4'hD : 4'h5;
      end
      S_DLO: begin
        o_mrxdv  = 1'b1;
        o_mrxd   = byte_q[3:0];
        o_mrxerr = err_q;
      end
      S_DHI: begin
        o_mrxdv  = 1'b1;
        o_mrxd   = byte_q[7:4];
        o_mrxerr = err_q;
      end
      S_FCS: begin
        o_mrxdv = 1'b1;
        o_mrxd  = fcs[{cnt_q[2:0], 2'b00} +: 4];
      end
      S_ABORT: begin
        o_mrxdv    = 1'b1;
        o_mrxerr   = 1'b1;
        o_underrun = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_data_ready = ready_q;

endmodule
